// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a big-endian byte stream into 16-bit words,
// then serves them to the core while holding it in reset until the program is complete.
module imem_loader (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  input  logic        reload_i,
  input  logic [7:0]  insaddr_i,
  output logic [15:0] insdata_o,
  output logic        core_rst_o,
  output logic        load_done_o,
  output logic [8:0]  word_count_o
);

  typedef enum logic [1:0] {StWaitHi, StWaitLo, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  hi_hold_q, hi_hold_d;
  logic [8:0]  word_count_q, word_count_d;
  logic [15:0] mem_q [256];
  logic        accept;
  logic        mem_we;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    hi_hold_d    = hi_hold_q;
    word_count_d = word_count_q;
    mem_we       = 1'b0;
    ld_ready_o   = !rst_i && (state_q != StRun);
    accept       = ld_valid_i && ld_ready_o;

    case (state_q)
      StWaitHi: begin
        if (accept) begin
          hi_hold_d = ld_data_i;
          state_d   = StWaitLo;
        end
      end
      StWaitLo: begin
        if (accept) begin
          mem_we       = 1'b1;
          word_count_d = word_count_q + 9'd1;
          // The last slot is terminal: saturate rather than wrap onto word 0.
          wr_ptr_d     = (wr_ptr_q == 8'hFF) ? wr_ptr_q : wr_ptr_q + 8'd1;
          state_d      = (ld_last_i || (wr_ptr_q == 8'hFF)) ? StRun : StWaitHi;
        end
      end
      StRun: begin
        if (reload_i) begin
          state_d      = StWaitHi;
          wr_ptr_d     = '0;
          word_count_d = '0;
        end
      end
      default: state_d = StWaitHi;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StWaitHi;
      wr_ptr_q     <= '0;
      hi_hold_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      hi_hold_q    <= hi_hold_d;
      word_count_q <= word_count_d;
    end
  end

  // Memory is deliberately not reset; only the load path writes it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {hi_hold_q, ld_data_i};
    end
  end

  always_comb begin
    insdata_o = 16'h0000;
    // Gate by word_count so stale words from an older, longer load read as NOP.
    if (!rst_i && (state_q == StRun) && ({1'b0, insaddr_i} < word_count_q)) begin
      insdata_o = mem_q[insaddr_i];
    end
  end

  assign core_rst_o   = rst_i || (state_q != StRun);
  assign load_done_o  = !rst_i && (state_q == StRun);
  assign word_count_o = word_count_q;

endmodule
